// File: rtl/i2s_mic_receiver.sv
// I2S master/receiver: generates SCK/WS, assembles stereo frames of WIDTH-bit samples,
// drops the settling frames after enable and hands frames out on a valid/ready port.
module i2s_mic_receiver #(
  parameter int unsigned WIDTH          = 24,
  parameter int unsigned SLOT_BITS      = 32,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned STARTUP_FRAMES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sd_i,
  output logic             sck_o,
  output logic             ws_o,
  output logic [WIDTH-1:0] left_o,
  output logic [WIDTH-1:0] right_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  input  logic             overrun_clr_i,
  output logic             busy_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(SLOT_BITS);
  localparam int unsigned SU_W  = $clog2(STARTUP_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [SU_W-1:0]    r_startup;
  logic               r_sck;
  logic               r_ws;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_left_hold;
  logic               r_cmp;
  logic [WIDTH-1:0]   r_left;
  logic [WIDTH-1:0]   r_right;
  logic               r_valid;
  logic               r_overrun;
  logic               r_busy;

  logic               w_active;
  logic               w_tick;
  logic               w_rise;
  logic               w_fall;
  logic               w_last_bit;
  logic               w_frame_end;
  logic               w_data_bit;
  logic               w_word_done;
  logic               w_deliver;
  logic [WIDTH-1:0]   w_shift;

  assign w_active    = (r_state != S_IDLE);
  assign w_tick      = w_active && (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_rise      = w_tick && !r_sck;
  assign w_fall      = w_tick && r_sck;
  assign w_last_bit  = (r_bit_cnt == BIT_W'(SLOT_BITS - 1));
  assign w_frame_end = w_fall && w_last_bit && r_ws;
  assign w_data_bit  = (r_bit_cnt != '0) && (r_bit_cnt <= BIT_W'(WIDTH));
  assign w_word_done = w_rise && (r_bit_cnt == BIT_W'(WIDTH));
  assign w_shift     = {r_shreg[WIDTH-2:0], sd_i};
  // Shift register and left hold stay untouched for many clk cycles after completion.
  assign w_deliver   = r_cmp && (r_state == S_RUN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en_i) w_next_state = S_WARMUP;
      end
      S_WARMUP: begin
        if (w_frame_end) begin
          if (!en_i)                       w_next_state = S_IDLE;
          else if (r_startup == SU_W'(1))  w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_frame_end && !en_i) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // SCK/WS generation and slot bit position
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
      r_bit_cnt <= '0;
      r_ws      <= 1'b0;
      r_startup <= SU_W'(STARTUP_FRAMES);
    end else if (!w_active) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
      r_bit_cnt <= '0;
      r_ws      <= 1'b0;
      r_startup <= SU_W'(STARTUP_FRAMES);
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) r_sck <= ~r_sck;
      if (w_fall) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_W'(1);
        if (w_last_bit) r_ws <= ~r_ws;
      end
      if (w_frame_end && (r_state == S_WARMUP)) r_startup <= r_startup - SU_W'(1);
    end
  end

  // Sample SD on rising SCK; dummy bit and tristated tail bits are skipped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shreg     <= '0;
      r_left_hold <= '0;
      r_cmp       <= 1'b0;
    end else begin
      if (w_rise && w_data_bit)     r_shreg     <= w_shift;
      if (w_word_done && !r_ws)     r_left_hold <= w_shift;
      r_cmp <= w_word_done && r_ws;
    end
  end

  // Frame hand-off with sticky overrun; a set beats a simultaneous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_deliver && (!r_valid || ready_i)) begin
        r_left  <= r_left_hold;
        r_right <= r_shreg;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_deliver && r_valid && !ready_i) r_overrun <= 1'b1;
      else if (overrun_clr_i)               r_overrun <= 1'b0;
      r_busy <= (w_next_state != S_IDLE);
    end
  end

  assign sck_o     = r_sck;
  assign ws_o      = r_ws;
  assign left_o    = r_left;
  assign right_o   = r_right;
  assign valid_o   = r_valid;
  assign overrun_o = r_overrun;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_i2s_mic_receiver.sv
// Bench for i2s_mic_receiver: PCM ROM mic emulator, frame-timing reference model
// compared every cycle, plus directed literal checks on reset, timing, data and handshake.
`timescale 1ns/1ps
module tb_i2s_mic_receiver;

  localparam int unsigned WIDTH     = 24;
  localparam int unsigned SLOT_BITS = 32;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned STARTUP   = 2;
  localparam int unsigned FRAME     = 2 * SLOT_BITS * 2 * CLK_DIV;
  localparam int unsigned HALF      = FRAME / 2;
  // Edge (counted from the enable edge) at which valid_o updates for a frame.
  localparam int unsigned DELIV_K   = 2 * CLK_DIV * (SLOT_BITS + WIDTH) + CLK_DIV + 1;
  localparam int unsigned JUNK      = 1000;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic             sd_i;
  logic             sck_o;
  logic             ws_o;
  logic [WIDTH-1:0] left_o;
  logic [WIDTH-1:0] right_o;
  logic             valid_o;
  logic             ready_i;
  logic             overrun_o;
  logic             overrun_clr_i;
  logic             busy_o;

  i2s_mic_receiver #(
    .WIDTH(WIDTH), .SLOT_BITS(SLOT_BITS), .CLK_DIV(CLK_DIV), .STARTUP_FRAMES(STARTUP)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .sd_i(sd_i), .sck_o(sck_o), .ws_o(ws_o),
    .left_o(left_o), .right_o(right_o), .valid_o(valid_o), .ready_i(ready_i),
    .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] rom_l [4];
  logic [WIDTH-1:0] rom_r [4];

  int checks = 0;
  int errors = 0;

  // Reference model state (values the DUT outputs must hold after the latest edge)
  bit               m_active, m_sck, m_ws, m_busy, m_valid, m_ovr;
  int unsigned      m_k, m_addr;
  logic [WIDTH-1:0] m_left, m_right;

  // Observer state
  int cyc = 0;
  int sck_toggles = 0;
  int last_rise = -1, rise_period = 0;
  int last_ws = -1, ws_period = 0;
  int first_valid = -1;
  logic obs_sck = 1'b0, obs_ws = 1'b0, obs_valid = 1'b0;

  // Emulator state
  int unsigned emu_bit, emu_addr;
  logic        emu_ws, emu_prev_sck;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_sck = 0; m_ws = 0; m_busy = 0; m_valid = 0; m_ovr = 0;
    m_k = 0; m_addr = 0; m_left = '0; m_right = '0;
  endtask

  // Advance the model across the coming clock edge using the inputs it will sample.
  task automatic model_step();
    bit deliver;
    bit set_ovr;
    int unsigned kk;
    deliver = 0;
    set_ovr = 0;
    if (!m_active) begin
      if (en_i) begin
        m_active = 1; m_busy = 1; m_k = 0;
      end
    end else begin
      m_k++;
      kk    = m_k % FRAME;
      m_sck = ((kk / CLK_DIV) % 2) == 1;
      m_ws  = (kk >= HALF);
      if (kk == 0) begin
        m_addr++;
        if (!en_i) begin
          m_active = 0; m_busy = 0;
        end
      end
      deliver = (kk == DELIV_K) && (m_k / FRAME >= STARTUP);
    end
    if (deliver) begin
      if (!m_valid || ready_i) begin
        m_valid = 1;
        m_left  = rom_l[m_addr % 4];
        m_right = rom_r[m_addr % 4];
      end else begin
        set_ovr = 1;
      end
    end else if (m_valid && ready_i) begin
      m_valid = 0;
    end
    if (set_ovr)            m_ovr = 1;
    else if (overrun_clr_i) m_ovr = 0;
  endtask

  // Compare process: every cycle, away from the active edge
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst_i) model_reset();
      checks++;
      if ({sck_o, ws_o, busy_o, valid_o, overrun_o, left_o, right_o} !==
          {m_sck, m_ws, m_busy, m_valid, m_ovr, m_left, m_right}) begin
        errors++;
        $display("FAIL model cycle %0d: got sck=%b ws=%b busy=%b valid=%b ovr=%b L=%h R=%h want sck=%b ws=%b busy=%b valid=%b ovr=%b L=%h R=%h",
                 cyc, sck_o, ws_o, busy_o, valid_o, overrun_o, left_o, right_o,
                 m_sck, m_ws, m_busy, m_valid, m_ovr, m_left, m_right);
      end
      if (!rst_i) model_step();
    end
  end

  // Observer: cycle count, SCK/WS periods, WS moving only with falling SCK
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sck_o !== obs_sck) begin
        sck_toggles++;
        if (sck_o === 1'b1) begin
          if (last_rise >= 0) rise_period = cyc - last_rise;
          last_rise = cyc;
        end
      end
      if (ws_o !== obs_ws) begin
        if (last_ws >= 0) ws_period = cyc - last_ws;
        last_ws = cyc;
        chk("ws_on_fall", {30'd0, obs_sck, sck_o}, 32'h2);
      end
      if (valid_o === 1'b1 && obs_valid === 1'b0 && first_valid < 0) first_valid = cyc;
      obs_sck   = sck_o;
      obs_ws    = ws_o;
      obs_valid = valid_o;
    end
  end

  task automatic emu_reset();
    emu_bit = JUNK; emu_addr = 0; emu_ws = 1'b0; emu_prev_sck = 1'b0;
    sd_i = 1'($urandom);
  endtask

  // PCM ROM mic emulator: syncs on WS edges, shifts data out after falling SCK
  initial begin
    logic [WIDTH-1:0] word;
    emu_reset();
    forever begin
      @(posedge clk);
      #2;
      if (rst_i) begin
        emu_reset();
      end else if (emu_prev_sck && !sck_o) begin
        if (ws_o != emu_ws) begin
          emu_ws  = ws_o;
          emu_bit = 0;
          if (!ws_o) emu_addr++;
        end else if (emu_bit < JUNK) begin
          emu_bit++;
        end
        word = emu_ws ? rom_r[emu_addr % 4] : rom_l[emu_addr % 4];
        if (emu_bit >= 1 && emu_bit <= WIDTH) sd_i = word[WIDTH - emu_bit];
        else                                  sd_i = 1'($urandom);
      end
      emu_prev_sck = sck_o;
    end
  end

  task automatic wait_k(input int unsigned target);
    int n;
    n = 0;
    while (!(m_active && m_k == target) && n < 20000) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL wait_k: timeout got k=%0d required k=%0d", m_k, target);
    end
  endtask

  task automatic chk_frame(input string name, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    chk({name, "_valid"}, 32'(valid_o), 32'd1);
    chk({name, "_left"},  32'(left_o),  32'(l));
    chk({name, "_right"}, 32'(right_o), 32'(r));
  endtask

  initial begin
    int t0, en_cyc;
    rom_l = '{24'h800000, 24'h7FFFFF, 24'h000001, 24'hA5A5A5};
    rom_r = '{24'hFFFFFF, 24'h000000, 24'h123456, 24'h5A5A5A};
    rst_i = 1'b1; en_i = 1'b0; ready_i = 1'b0; overrun_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck",   32'(sck_o),   32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);
    @(posedge clk); #2;
    rst_i = 1'b0;

    t0 = sck_toggles;
    repeat (1000) @(posedge clk);
    #2;
    chk("idle_no_sck", 32'(sck_toggles - t0), 32'd0);

    // Run 1: data ordering with ready held high
    ready_i = 1'b1; en_i = 1'b1; en_cyc = cyc;
    wait_k(2 * FRAME + DELIV_K);
    chk("first_valid_latency", 32'(first_valid - en_cyc), 32'd1478);
    chk("sck_period", 32'(rise_period), 32'd8);
    chk("ws_period",  32'(ws_period),   32'd256);
    chk_frame("frame2", 24'h000001, 24'h123456);
    wait_k(3 * FRAME + DELIV_K);
    chk_frame("frame3", 24'hA5A5A5, 24'h5A5A5A);
    wait_k(4 * FRAME + DELIV_K);
    chk_frame("frame4", 24'h800000, 24'hFFFFFF);
    wait_k(5 * FRAME + DELIV_K + 1);
    ready_i = 1'b0;

    // Backpressure: frame 6 held, frame 7 dropped
    wait_k(6 * FRAME + DELIV_K);
    chk_frame("hold6", 24'h000001, 24'h123456);
    wait_k(7 * FRAME + DELIV_K + 1);
    chk("overrun_set", 32'(overrun_o), 32'd1);
    chk_frame("held_after_drop", 24'h000001, 24'h123456);
    overrun_clr_i = 1'b1;
    @(posedge clk); #2;
    overrun_clr_i = 1'b0;
    chk("overrun_clr", 32'(overrun_o), 32'd0);
    ready_i = 1'b1;
    @(posedge clk); #2;
    ready_i = 1'b0;
    chk("transfer_drop_valid", 32'(valid_o), 32'd0);
    wait_k(8 * FRAME + DELIV_K);
    chk_frame("frame8", 24'h800000, 24'hFFFFFF);

    // Ready in the exact completion cycle while a frame is held
    wait_k(9 * FRAME + DELIV_K - 1);
    ready_i = 1'b1;
    @(posedge clk); #2;
    ready_i = 1'b0;
    chk_frame("simul9", 24'h7FFFFF, 24'h000000);
    chk("simul_no_ovr", 32'(overrun_o), 32'd0);
    wait_k(10 * FRAME + DELIV_K + 1);
    chk("overrun10", 32'(overrun_o), 32'd1);

    // Asynchronous reset mid right slot
    wait_k(11 * FRAME + 300);
    rst_i = 1'b1; en_i = 1'b0;
    #1;
    chk("mid_rst_sck",   32'(sck_o),     32'd0);
    chk("mid_rst_ws",    32'(ws_o),      32'd0);
    chk("mid_rst_valid", 32'(valid_o),   32'd0);
    chk("mid_rst_ovr",   32'(overrun_o), 32'd0);
    chk("mid_rst_busy",  32'(busy_o),    32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;

    // Run 2: disable during left slot bit 5 of the first delivered frame
    ready_i = 1'b1; en_i = 1'b1;
    wait_k(2 * FRAME + 42);
    en_i = 1'b0;
    wait_k(2 * FRAME + DELIV_K);
    chk_frame("disable_frame", 24'h000001, 24'h123456);
    chk("disable_busy_mid", 32'(busy_o), 32'd1);
    repeat (FRAME - DELIV_K + 2) @(posedge clk);
    #2;
    chk("disable_busy", 32'(busy_o), 32'd0);
    chk("disable_sck",  32'(sck_o),  32'd0);
    chk("disable_ws",   32'(ws_o),   32'd0);
    t0 = sck_toggles;
    repeat (200) @(posedge clk);
    #2;
    chk("disable_no_sck", 32'(sck_toggles - t0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
